// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares the single-port PMEM (psum SRAM) between three requesters:
//   wb  : OFIFO writeback, write-only
//   sfp : SFP normalization, read/write, may lock the port for read-modify-write
//   rd  : final output readout, read-only
//
// Arbitration is round-robin (WB -> SFP -> RD, starting after the last served
// agent) with a bounded burst length. The current owner keeps the port while
// its burst is below MAX_BURST, while nobody else is asking, or while SFP holds
// sfp_lock. Grants are combinational in the request cycle. SRAM pins are
// registered, so a grant in cycle t drives the macro in t+1. The macro returns
// data in t+2, where it is tagged with a one-cycle rvalid for the issuer.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   wb_req/addr/data      writeback request, wb_gnt grant
//   sfp_req/we/addr/wdata sfp request (we=1 write), sfp_lock holds ownership
//   rd_req/addr           readout request, rd_gnt grant
//   rdata                 read data (straight from pmem_q)
//   sfp_rvalid/rd_rvalid  rdata valid for that requester
//   pmem_cen/wen          registered SRAM chip/write enable, active-low
//   pmem_addr/pmem_d      registered SRAM address / write data
//   pmem_q                SRAM read data
//   busy                  registered: transfer issued last cycle or read in flight
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int DW        = 128,
  parameter int AW        = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_gnt,
  input  logic          sfp_req,
  input  logic          sfp_we,
  input  logic [AW-1:0] sfp_addr,
  input  logic [DW-1:0] sfp_wdata,
  input  logic          sfp_lock,
  output logic          sfp_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic [DW-1:0] rdata,
  output logic          sfp_rvalid,
  output logic          rd_rvalid,
  output logic          pmem_cen,
  output logic          pmem_wen,
  output logic [AW-1:0] pmem_addr,
  output logic [DW-1:0] pmem_d,
  input  logic [DW-1:0] pmem_q,
  output logic          busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WB   = 2'd1,
    OWN_SFP  = 2'd2,
    OWN_RD   = 2'd3
  } owner_e;

  owner_e         owner_r;
  owner_e         owner_next_s;
  owner_e         last_r;
  owner_e         last_next_s;
  owner_e         win_s;
  logic [CW-1:0]  burst_cnt_r;
  logic [CW-1:0]  burst_cnt_next_s;
  logic           own_req_s;
  logic           others_req_s;
  logic           keep_s;

  logic           cmd_cen_s;
  logic           cmd_wen_s;
  logic [AW-1:0]  cmd_addr_s;
  logic [DW-1:0]  cmd_d_s;
  logic           cmd_d_load_s;
  logic           sfp_read_s;
  logic           rd_read_s;

  // Read issued on the pins this cycle; data comes back from the macro next cycle.
  logic           sfp_p1_r;
  logic           rd_p1_r;

  // First requesting agent in cyclic order WB -> SFP -> RD, starting after last_owner.
  function automatic owner_e rr_pick(input owner_e last_owner, input logic wb,
                                     input logic sfp, input logic rd);
    owner_e pick;
    pick = OWN_NONE;
    case (last_owner)
      OWN_WB: begin
        if (sfp)      pick = OWN_SFP;
        else if (rd)  pick = OWN_RD;
        else if (wb)  pick = OWN_WB;
        else          pick = OWN_NONE;
      end
      OWN_SFP: begin
        if (rd)       pick = OWN_RD;
        else if (wb)  pick = OWN_WB;
        else if (sfp) pick = OWN_SFP;
        else          pick = OWN_NONE;
      end
      default: begin
        if (wb)       pick = OWN_WB;
        else if (sfp) pick = OWN_SFP;
        else if (rd)  pick = OWN_RD;
        else          pick = OWN_NONE;
      end
    endcase
    return pick;
  endfunction

  // Arbitration: pick this cycle's grantee (owner continuation or round-robin).
  always_comb begin
    own_req_s    = 1'b0;
    others_req_s = 1'b0;
    keep_s       = 1'b0;
    win_s        = OWN_NONE;
    case (owner_r)
      OWN_WB: begin
        own_req_s    = wb_req;
        others_req_s = sfp_req | rd_req;
      end
      OWN_SFP: begin
        own_req_s    = sfp_req;
        others_req_s = wb_req | rd_req;
      end
      OWN_RD: begin
        own_req_s    = rd_req;
        others_req_s = wb_req | sfp_req;
      end
      default: begin
        own_req_s    = 1'b0;
        others_req_s = 1'b0;
      end
    endcase
    // Lock only counts once SFP already owns the port.
    keep_s = own_req_s &&
             ((burst_cnt_r < CNT_MAX) || !others_req_s ||
              ((owner_r == OWN_SFP) && sfp_lock));
    if (!reset) begin
      win_s = OWN_NONE;
    end else if (keep_s) begin
      win_s = owner_r;
    end else begin
      win_s = rr_pick(last_r, wb_req, sfp_req, rd_req);
    end
  end

  assign wb_gnt  = (win_s == OWN_WB);
  assign sfp_gnt = (win_s == OWN_SFP);
  assign rd_gnt  = (win_s == OWN_RD);
  assign rdata   = pmem_q;

  // Ownership / burst / round-robin pointer next state.
  always_comb begin
    owner_next_s     = OWN_NONE;
    last_next_s      = last_r;
    burst_cnt_next_s = CNT_ZERO;
    if (win_s == OWN_NONE) begin
      owner_next_s     = OWN_NONE;
      burst_cnt_next_s = CNT_ZERO;
    end else begin
      owner_next_s = win_s;
      last_next_s  = win_s;
      if (win_s != owner_r) begin
        burst_cnt_next_s = CNT_ONE;
      end else if (burst_cnt_r < CNT_MAX) begin
        burst_cnt_next_s = burst_cnt_r + CNT_ONE;
      end else begin
        burst_cnt_next_s = burst_cnt_r;
      end
    end
  end

  // Arbiter state register; last resets to RD so WB is first in line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_r     <= OWN_NONE;
      last_r      <= OWN_RD;
      burst_cnt_r <= CNT_ZERO;
    end else begin
      owner_r     <= owner_next_s;
      last_r      <= last_next_s;
      burst_cnt_r <= burst_cnt_next_s;
    end
  end

  // SRAM command decode for the grantee; idle holds address and data.
  always_comb begin
    cmd_cen_s    = 1'b1;
    cmd_wen_s    = 1'b1;
    cmd_addr_s   = pmem_addr;
    cmd_d_s      = pmem_d;
    cmd_d_load_s = 1'b0;
    sfp_read_s   = 1'b0;
    rd_read_s    = 1'b0;
    case (win_s)
      OWN_WB: begin
        cmd_cen_s    = 1'b0;
        cmd_wen_s    = 1'b0;
        cmd_addr_s   = wb_addr;
        cmd_d_s      = wb_data;
        cmd_d_load_s = 1'b1;
      end
      OWN_SFP: begin
        cmd_cen_s    = 1'b0;
        cmd_wen_s    = ~sfp_we;
        cmd_addr_s   = sfp_addr;
        cmd_d_s      = sfp_wdata;
        cmd_d_load_s = sfp_we;
        sfp_read_s   = ~sfp_we;
      end
      OWN_RD: begin
        cmd_cen_s  = 1'b0;
        cmd_wen_s  = 1'b1;
        cmd_addr_s = rd_addr;
        rd_read_s  = 1'b1;
      end
      default: begin
        cmd_cen_s    = 1'b1;
        cmd_wen_s    = 1'b1;
        cmd_addr_s   = pmem_addr;
        cmd_d_s      = pmem_d;
        cmd_d_load_s = 1'b0;
      end
    endcase
  end

  // Registered SRAM pins; write data only moves on a write so reads leave it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= {AW{1'b0}};
      pmem_d    <= {DW{1'b0}};
    end else begin
      pmem_cen  <= cmd_cen_s;
      pmem_wen  <= cmd_wen_s;
      pmem_addr <= cmd_addr_s;
      if (cmd_d_load_s) begin
        pmem_d <= cmd_d_s;
      end else begin
        pmem_d <= pmem_d;
      end
    end
  end

  // Read return pipeline: grant -> pins -> macro output; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sfp_p1_r   <= 1'b0;
      rd_p1_r    <= 1'b0;
      sfp_rvalid <= 1'b0;
      rd_rvalid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sfp_p1_r   <= sfp_read_s;
      rd_p1_r    <= rd_read_s;
      sfp_rvalid <= sfp_p1_r;
      rd_rvalid  <= rd_p1_r;
      busy       <= (win_s != OWN_NONE) | sfp_p1_r | rd_p1_r;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Drives pmem_arbiter with directed scenarios followed by random traffic, with
// a simple synchronous SRAM model on the PMEM pins. A reference model tracks
// owner / run length / last-served agent and a reference memory; it predicts
// grants, SRAM pins and busy each cycle, and pushes expected read returns into
// per-requester queues that a separate monitor pops on each rvalid.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int DW   = 128;
  localparam int AW   = 4;
  localparam int MAXB = 8;

  logic          clk;
  logic          reset;
  logic          wb_req, sfp_req, sfp_we, sfp_lock, rd_req;
  logic [AW-1:0] wb_addr, sfp_addr, rd_addr;
  logic [DW-1:0] wb_data, sfp_wdata;
  logic          wb_gnt, sfp_gnt, rd_gnt;
  logic [DW-1:0] rdata;
  logic          sfp_rvalid, rd_rvalid;
  logic          pmem_cen, pmem_wen;
  logic [AW-1:0] pmem_addr;
  logic [DW-1:0] pmem_d;
  logic [DW-1:0] pmem_q;
  logic          busy;

  pmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .sfp_req(sfp_req), .sfp_we(sfp_we), .sfp_addr(sfp_addr), .sfp_wdata(sfp_wdata),
    .sfp_lock(sfp_lock), .sfp_gnt(sfp_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rdata(rdata), .sfp_rvalid(sfp_rvalid), .rd_rvalid(rd_rvalid),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .pmem_d(pmem_d),
    .pmem_q(pmem_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port SRAM: q registered one cycle after a read command.
  logic [DW-1:0] sram [16];
  always @(posedge clk) begin
    if (!pmem_cen) begin
      if (!pmem_wen) sram[pmem_addr] <= pmem_d;
      else           pmem_q <= sram[pmem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            known;
  } rexp_t;

  rexp_t         sfp_q[$];
  rexp_t         rd_q[$];
  logic [DW-1:0] ref_mem [16];
  bit            ref_known [16];

  int            own   = 0;   // 0 none, 1 wb, 2 sfp, 3 rd
  int            run   = 0;   // consecutive transfers by own
  int            lastw = 3;   // last served agent
  bit            exp_cen = 1'b1, exp_wen = 1'b1, exp_busy = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_d = '0;
  bit            d_chk = 1'b1;
  bit            prev_read = 1'b0;
  int            dut_g;
  int            rd_seen = 0;

  function automatic int arb(input bit [3:0] rq, input bit lock);
    int others;
    others = 0;
    for (int a = 1; a <= 3; a++) if (a != own && rq[a]) others++;
    if (own != 0 && rq[own] && (run < MAXB || others == 0 || (own == 2 && lock))) return own;
    for (int k = 1; k <= 3; k++) begin
      int a;
      a = (lastw + k - 1) % 3 + 1;
      if (rq[a]) return a;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: check last edge's outcome, drive inputs, check grants, advance model.
  task automatic tick(input bit rst_v,
                      input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit sr, input bit swe, input bit slk,
                      input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input bit rr, input logic [AW-1:0] ra);
    int    g;
    rexp_t e;
    @(negedge clk);
    chk("pmem_cen", 128'(pmem_cen), 128'(exp_cen));
    chk("pmem_wen", 128'(pmem_wen), 128'(exp_wen));
    chk("pmem_addr", 128'(pmem_addr), 128'(exp_addr));
    if (d_chk) chk("pmem_d", pmem_d, exp_d);
    chk("busy", 128'(busy), 128'(exp_busy));
    reset = rst_v;
    wb_req = wr;  wb_addr = wa;  wb_data = wd;
    sfp_req = sr; sfp_we = swe; sfp_lock = slk; sfp_addr = sa; sfp_wdata = sd;
    rd_req = rr;  rd_addr = ra;
    #1;
    g = rst_v ? arb({rr, sr, wr, 1'b0}, slk) : 0;
    dut_g = wb_gnt ? 1 : sfp_gnt ? 2 : rd_gnt ? 3 : 0;
    chk("grants", 128'({wb_gnt, sfp_gnt, rd_gnt}), 128'({g == 1, g == 2, g == 3}));
    if (!rst_v) begin
      own = 0; run = 0; lastw = 3;
      exp_cen = 1'b1; exp_wen = 1'b1; exp_addr = '0; exp_d = '0; d_chk = 1'b1;
      exp_busy = 1'b0; prev_read = 1'b0;
      while (sfp_q.size() > 0 && sfp_q[sfp_q.size()-1].due > cyc) void'(sfp_q.pop_back());
      while (rd_q.size() > 0 && rd_q[rd_q.size()-1].due > cyc) void'(rd_q.pop_back());
    end else begin
      exp_busy = (g != 0) || prev_read;
      prev_read = (g == 3) || (g == 2 && !swe);
      case (g)
        1: begin
          exp_cen = 1'b0; exp_wen = 1'b0; exp_addr = wa; exp_d = wd; d_chk = 1'b1;
          ref_mem[wa] = wd; ref_known[wa] = 1'b1;
        end
        2: begin
          exp_cen = 1'b0; exp_wen = ~swe; exp_addr = sa;
          if (swe) begin
            exp_d = sd; d_chk = 1'b1; ref_mem[sa] = sd; ref_known[sa] = 1'b1;
          end else begin
            d_chk = 1'b0;
            e.due = cyc + 2; e.data = ref_mem[sa]; e.known = ref_known[sa];
            sfp_q.push_back(e);
          end
        end
        3: begin
          exp_cen = 1'b0; exp_wen = 1'b1; exp_addr = ra; d_chk = 1'b0;
          e.due = cyc + 2; e.data = ref_mem[ra]; e.known = ref_known[ra];
          rd_q.push_back(e);
        end
        default: begin
          exp_cen = 1'b1; exp_wen = 1'b1;
        end
      endcase
      if (g != 0) begin
        run = (g == own) ? run + 1 : 1;
        own = g; lastw = g;
      end else begin
        own = 0; run = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Read-return monitor: every rvalid must match the oldest expected read of that requester.
  initial begin
    rexp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sfp_rvalid) begin
        if (sfp_q.size() == 0) chk("sfp_rvalid_unexpected", 128'(sfp_rvalid), 128'(1'b0));
        else begin
          e = sfp_q.pop_front();
          chk("sfp_rvalid_cycle", 128'(cyc), 128'(e.due));
          if (e.known) chk("sfp_rdata", rdata, e.data);
        end
      end else if (sfp_q.size() > 0 && sfp_q[0].due <= cyc) begin
        e = sfp_q.pop_front();
        chk("sfp_rvalid_missing", 128'(sfp_rvalid), 128'(1'b1));
      end
      if (rd_rvalid) begin
        if (rd_q.size() == 0) chk("rd_rvalid_unexpected", 128'(rd_rvalid), 128'(1'b0));
        else begin
          e = rd_q.pop_front();
          chk("rd_rvalid_cycle", 128'(cyc), 128'(e.due));
          if (e.known) chk("rd_rdata", rdata, e.data);
          rd_seen++;
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        chk("rd_rvalid_missing", 128'(rd_rvalid), 128'(1'b1));
      end
    end
  end

  initial begin
    int cnt;
    int seen0;
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    for (int i = 0; i < 16; i++) ref_known[i] = 1'b0;
    reset = 1'b0;
    wb_req = 1'b0; sfp_req = 1'b0; rd_req = 1'b0; sfp_we = 1'b0; sfp_lock = 1'b0;
    wb_addr = '0; sfp_addr = '0; rd_addr = '0; wb_data = '0; sfp_wdata = '0;

    // Reset with all requests high: no grants.
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, '0);

    // Full contention: 8 WB, 8 SFP, 8 RD, then WB again.
    for (int i = 0; i < 25; i++) begin
      tick(1'b1, 1'b1, 4'($urandom_range(0, 15)), rnd128(),
           1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), '0,
           1'b1, 4'($urandom_range(0, 15)));
      chk("rr_order", 128'(dut_g), 128'((i / MAXB) % 3 + 1));
    end

    // WB writes A5 to addr 3, RD reads it back.
    tick(1'b1, 1'b1, 4'd3, a5, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    idle(3);

    // WB alone: no burst limit without contention.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b1, 4'($urandom_range(0, 15)), rnd128(), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
      if (dut_g == 1) cnt++;
    end
    chk("wb_solo_run", 128'(cnt), 128'(20));
    idle(2);

    // SFP locked read-modify-write on addr 0..5 while WB waits.
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 4'd9, rnd128(), 1'b1, 1'(i % 2), 1'b1, 4'(i / 2), rnd128(), 1'b0, '0);
      if (dut_g == 2) cnt++;
    end
    chk("sfp_lock_run", 128'(cnt), 128'(12));
    tick(1'b1, 1'b1, 4'd9, rnd128(), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    chk("wb_after_lock", 128'(dut_g), 128'(1));
    idle(3);

    // Fill memory, then RD streams addr 0..15 back-to-back.
    for (int i = 0; i < 16; i++)
      tick(1'b1, 1'b1, 4'(i), rnd128(), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    seen0 = rd_seen;
    for (int i = 0; i < 16; i++)
      tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'(i));
    idle(4);
    chk("rd_stream_count", 128'(rd_seen - seen0), 128'(16));

    // Reset on the 4th cycle of an RD burst, then WB must win first.
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'(i));
    tick(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    tick(1'b1, 1'b1, 4'd7, rnd128(), 1'b1, 1'b0, 1'b0, 4'd1, '0, 1'b1, 4'd4);
    chk("wb_first_after_reset", 128'(dut_g), 128'(1));
    idle(3);

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 99) != 0,
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), rnd128(),
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)), rnd128(),
           $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
    end
    idle(4);
    chk("sfp_reads_drained", 128'(sfp_q.size()), 128'(0));
    chk("rd_reads_drained", 128'(rd_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbitrates the single-port PMEM (psum SRAM) between three requesters: OFIFO writeback (`wb`, write-only), SFP normalization (`sfp`, read/write with atomic read-modify-write lock) and final output readout (`rd`, read-only). It sits between the core controller's datapath and the PMEM macro and replaces direct `pmem_rd`/`pmem_wr`/`pmem_add` instruction-bit driving. Service is round-robin with a bounded burst length and registered SRAM pins, and read data is returned with fixed latency to the requester that issued the read.

## Interface
- `DW`, 128: PMEM data width (16-bit psum × 8 columns)
- `AW`, 4: PMEM address width
- `MAX_BURST`, 8: maximum consecutive transfers for one owner while another requester waits
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `wb_req` in 1, `wb_addr` in AW, `wb_data` in DW, `wb_gnt` out 1: writeback requester
- `sfp_req` in 1, `sfp_we` in 1, `sfp_addr` in AW, `sfp_wdata` in DW, `sfp_lock` in 1, `sfp_gnt` out 1: SFP requester
- `rd_req` in 1, `rd_addr` in AW, `rd_gnt` out 1: readout requester
- `rdata`  out  DW  read data, equals `pmem_q`
- `sfp_rvalid`, `rd_rvalid`  out  1  `rdata` valid for that requester
- `pmem_cen`, `pmem_wen`  out  1  SRAM chip/write enable, active-low, registered
- `pmem_addr`  out  AW, `pmem_d`  out  DW  registered SRAM address and write data
- `pmem_q`  in  DW  SRAM read data, valid one cycle after the command cycle
- `busy`  out  1  registered: a transfer was issued last cycle or a read is in flight

## Operation
- Registered state: `owner` ∈ {NONE, WB, SFP, RD}, `burst_cnt` (width clog2(MAX_BURST)+1), `last` (last served requester, for round-robin), read pipeline flags.
- Grant is combinational in the current cycle. If `owner`≠NONE, its req is high, and at least one of the following holds, the owner keeps the grant: `burst_cnt` < MAX_BURST; no other req is high; owner is SFP with `sfp_lock`=1. Otherwise the winner is the first requesting agent in cyclic order WB→SFP→RD, starting after `last`.
- A transfer occurs every cycle that a `*_gnt` is high. Exactly one grant is high at most. A requester must hold its address/data stable only in the cycle it is granted.
- On a transfer, `owner` becomes the grantee. `burst_cnt` is set to 1 on an owner change and incremented on a continuation, saturating at MAX_BURST. `last` becomes the grantee. With no grant, `owner` becomes NONE and `burst_cnt` becomes 0.
- Command encoding: WB gives `cen`=0 and `wen`=0. SFP gives `cen`=0 and `wen`=~`sfp_we`. RD gives `cen`=0 and `wen`=1. No grant gives `cen`=1 and `wen`=1, and `addr`/`d` hold their previous values.
- `sfp_lock` lets SFP do a read then a write to the same address without a WB write in between. Lock is ignored while SFP is not the owner.

## Timing
- Reset (`reset`=0 at edge): `owner`=NONE, `burst_cnt`=0, `last`=RD (so WB has first priority), `pmem_cen`=1, `pmem_wen`=1, `pmem_addr`=0, `pmem_d`=0, `busy`=0, both rvalids 0. Grants are 0 during reset regardless of req.
- A grant in cycle t causes the SRAM pins to change at the edge ending t. `pmem_q` is valid in cycle t+2, and `sfp_rvalid`/`rd_rvalid` is asserted in t+2 for one cycle per read.
- Reads are fully pipelined: back-to-back grants give back-to-back rvalids. A read followed by a write does not corrupt the returned data.
- If reset is asserted mid-burst, in-flight rvalids are dropped and no pin activity occurs in the reset cycle.
- If a req is deasserted while owner, the grant drops the same cycle and arbitration proceeds among the others.

## Test plan
- After reset, set `wb_req`=`sfp_req`=`rd_req`=1 and hold. Required: `wb_gnt` for 8 cycles, then `sfp_gnt` for 8, then `rd_gnt` for 8, then WB again. Exactly one grant per cycle.
- WB writes 0x…A5 to addr 3 (1 cycle), then RD reads addr 3. Required: `pmem_cen`=0/`wen`=0/`addr`=3 one cycle after the WB grant, and `rd_rvalid`=1 with `rdata`=0x…A5 two cycles after the RD grant.
- Only `wb_req`=1 for 20 cycles. Required: 20 continuous `wb_gnt`, because the burst limit does not apply without contention.
- SFP holds `sfp_lock`=1 for 12 transfers (6 read/write pairs on addr 0–5) while `wb_req`=1. Required: 12 uninterrupted SFP grants, then `wb_gnt` on the next cycle.
- RD streams addr 0–15 back-to-back. Required: 16 consecutive `rd_rvalid` pulses starting 2 cycles after the first grant, with data in address order.
- Assert reset on the 4th cycle of an RD burst. Required: all grants 0, `pmem_cen`=1, no further `rd_rvalid`, `busy`=0 after the reset edge, and WB wins first after release.
